// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage and the instruction memory.
package pc_pkg;

    // Run-control state encoding, also visible on the state output.
    typedef enum logic [1:0] {
        PC_RUN   = 2'b00,
        PC_HALT  = 2'b01,
        PC_FAULT = 2'b10
    } pc_state_e;

    // First fetch address: instruction memory word base 0x0010_0000 << 2.
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    // Highest legal fetch byte address: instruction memory word 0x0010_0100 << 2.
    localparam logic [31:0] DEF_PC_LIMIT     = 32'h0040_0400;

    // A fetch address is usable only if word aligned and inside the memory window.
    function automatic logic is_legal_pc(input logic [31:0] pc,
                                         input logic [31:0] lo,
                                         input logic [31:0] hi);
        return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/datapath inputs and fetch/status outputs of the program-counter stage.
interface pc_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        halt_req;
    logic [31:0] curr_pc;
    logic [31:0] pc_plus4;
    logic [1:0]  state;
    logic        fault;
    logic [31:0] retired_count;
    logic [31:0] cycle_count;

    // Decode/execute side: drives control decisions, observes the PC.
    modport master (
        output stall, branch_taken, branch_imm, jump, jump_target,
               jump_reg, reg_target, halt_req,
        input  curr_pc, pc_plus4, state, fault, retired_count, cycle_count
    );

    // Program-counter stage itself.
    modport slave (
        input  stall, branch_taken, branch_imm, jump, jump_target,
               jump_reg, reg_target, halt_req,
        output curr_pc, pc_plus4, state, fault, retired_count, cycle_count
    );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection and legality check.
module next_pc_calc
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] PC_LIMIT     = DEF_PC_LIMIT
) (
    input  logic [31:0] curr_pc_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_imm_i,
    input  logic        jump_i,
    input  logic [25:0] jump_target_i,
    input  logic        jump_reg_i,
    input  logic [31:0] reg_target_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        next_pc_legal_o
);

    logic [31:0] branch_off;

    assign pc_plus4_o = curr_pc_i + 32'd4;
    // Word offset scaled to bytes; the sum wraps silently.
    assign branch_off = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};

    // Priority: jr over j/jal over taken branch over fall-through.
    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_reg_i) begin
            next_pc_o = reg_target_i;
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc_o = pc_plus4_o + branch_off;
        end
    end

    assign next_pc_legal_o = is_legal_pc(next_pc_o, RESET_VECTOR, PC_LIMIT);

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, run/halt/fault control and counters.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] PC_LIMIT     = DEF_PC_LIMIT
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_unit_if.slave bus
);

    pc_state_e   state_q;
    logic        fault_q;
    logic [31:0] pc_q;
    logic [31:0] retired_q;
    logic [31:0] cycle_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        legal_d;

    next_pc_calc #(
        .RESET_VECTOR (RESET_VECTOR),
        .PC_LIMIT     (PC_LIMIT)
    ) u_calc (
        .curr_pc_i       (pc_q),
        .branch_taken_i  (bus.branch_taken),
        .branch_imm_i    (bus.branch_imm),
        .jump_i          (bus.jump),
        .jump_target_i   (bus.jump_target),
        .jump_reg_i      (bus.jump_reg),
        .reg_target_i    (bus.reg_target),
        .next_pc_o       (pc_d),
        .pc_plus4_o      (pc_plus4_d),
        .next_pc_legal_o (legal_d)
    );

    // Run-control FSM with PC and counters; HALT/FAULT freeze everything until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PC_RUN;
            fault_q   <= 1'b0;
            pc_q      <= RESET_VECTOR;
            retired_q <= '0;
            cycle_q   <= '0;
        end else begin
            case (state_q)
                PC_RUN: begin
                    cycle_q <= cycle_q + 32'd1;
                    if (!bus.stall) begin
                        if (bus.halt_req) begin
                            // The exit syscall retires; PC stays on it.
                            state_q   <= PC_HALT;
                            retired_q <= retired_q + 32'd1;
                        end else if (!legal_d) begin
                            // PC stays on the faulting instruction, which does not retire.
                            state_q <= PC_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            pc_q      <= pc_d;
                            retired_q <= retired_q + 32'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.curr_pc       = pc_q;
    assign bus.pc_plus4      = pc_plus4_d;
    assign bus.state         = state_q;
    assign bus.fault         = fault_q;
    assign bus.retired_count = retired_q;
    assign bus.cycle_count   = cycle_q;

endmodule
